// File: rtl/fdma_buf_pkg.sv
// Shared definitions for the FDMA frame-buffer scheduler: widths, FSM encodings and the
// buffer base-address helper used to build the constant address table.
package fdma_buf_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [0:0] W_IDLE   = 1'b0;
  localparam logic [0:0] W_ACTIVE = 1'b1;
  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_ACTIVE = 1'b1;

  // Elaboration-time only; callers truncate to their address width.
  function automatic logic [63:0] buf_addr(input logic [63:0] base, input logic [63:0] stride,
                                           input int unsigned idx);
    return base + stride * 64'(idx);
  endfunction

endpackage

// File: rtl/fdma_buf_sched_if.sv
// Frame-start/done inputs and start/index/address/status outputs of the buffer scheduler.
interface fdma_buf_sched_if #(
  parameter int unsigned ADDR_W = 32
);
  import fdma_buf_pkg::*;

  logic              wr_fs_i;
  logic              wr_done_i;
  logic              rd_fs_i;
  logic              rd_done_i;
  logic              wr_start_o;
  logic [IDX_W-1:0]  wr_idx_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              rd_start_o;
  logic [IDX_W-1:0]  rd_idx_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              frame_valid_o;
  logic [CNT_W-1:0]  drop_cnt_o;
  logic [CNT_W-1:0]  repeat_cnt_o;

  modport master (
    output wr_fs_i, wr_done_i, rd_fs_i, rd_done_i,
    input  wr_start_o, wr_idx_o, wr_addr_o, rd_start_o, rd_idx_o, rd_addr_o,
    input  frame_valid_o, drop_cnt_o, repeat_cnt_o
  );

  modport slave (
    input  wr_fs_i, wr_done_i, rd_fs_i, rd_done_i,
    output wr_start_o, wr_idx_o, wr_addr_o, rd_start_o, rd_idx_o, rd_addr_o,
    output frame_valid_o, drop_cnt_o, repeat_cnt_o
  );

endinterface

// File: rtl/fdma_buf_idx_sel.sv
// Combinational write-buffer picker: first of cur+1, cur+2, ... (mod BUF_NUM) that is neither
// locked by the reader nor the latest completed frame; falls back to the current index.
module fdma_buf_idx_sel
  import fdma_buf_pkg::*;
#(
  parameter int unsigned BUF_NUM = 3
) (
  input  logic [IDX_W-1:0] cur_idx_i,
  input  logic [IDX_W-1:0] lock_idx_i,
  input  logic             lock_vld_i,
  input  logic [IDX_W-1:0] done_idx_i,
  input  logic             done_vld_i,
  output logic [IDX_W-1:0] sel_idx_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    sel_idx_o = cur_idx_i;
    sum       = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k < BUF_NUM; k++) begin
      // cur < BUF_NUM and k < BUF_NUM, so one conditional subtract wraps the sum
      sum = {1'b0, cur_idx_i} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(BUF_NUM)) begin
        sum = sum - (IDX_W + 1)'(BUF_NUM);
      end
      cand = sum[IDX_W-1:0];
      if (!found && !(lock_vld_i && (cand == lock_idx_i)) &&
          !(done_vld_i && (cand == done_idx_i))) begin
        sel_idx_o = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdma_buf_sched.sv
// Triple-buffer scheduler: hands out write/read buffer indices and base addresses and
// issues one-cycle start pulses, keeping the writer off the buffer being read.
module fdma_buf_sched
  import fdma_buf_pkg::*;
#(
  parameter int unsigned       BUF_NUM     = 3,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] FRAME_BYTES = 32'h0080_0000
) (
  input logic            clk_i,
  input logic            rst_i,
  fdma_buf_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_TAB [4] = '{
    ADDR_W'(buf_addr(64'(BASE_ADDR), 64'(FRAME_BYTES), 0)),
    ADDR_W'(buf_addr(64'(BASE_ADDR), 64'(FRAME_BYTES), 1)),
    ADDR_W'(buf_addr(64'(BASE_ADDR), 64'(FRAME_BYTES), 2)),
    ADDR_W'(buf_addr(64'(BASE_ADDR), 64'(FRAME_BYTES), 3))
  };

  logic [0:0]        w_state_q, w_state_d, r_state_q, r_state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, last_done_q, last_done_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic              done_valid_q, done_valid_d, wr_start_q, wr_start_d, rd_start_q, rd_start_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d, repeat_cnt_q, repeat_cnt_d;

  logic             w_active, r_active, w_retire, w_accept, w_drop, r_accept;
  logic [IDX_W-1:0] wr_sel, sel_done_idx, sel_lock_idx;
  logic             sel_done_vld, sel_lock_vld;

  assign w_active = (w_state_q == W_ACTIVE);
  assign r_active = (r_state_q == R_ACTIVE);
  assign w_retire = w_active && bus.wr_done_i;
  assign w_accept = bus.wr_fs_i && (!w_active || bus.wr_done_i);
  assign w_drop   = w_active && bus.wr_fs_i && !bus.wr_done_i;
  assign r_accept = !r_active && bus.rd_fs_i && done_valid_q;

  // A same-cycle retire is visible to the picker; a same-cycle read choice is locked
  assign sel_done_idx = w_retire ? wr_idx_q : last_done_q;
  assign sel_done_vld = w_retire || done_valid_q;
  assign sel_lock_idx = r_accept ? last_done_q : rd_idx_q;
  assign sel_lock_vld = r_accept || r_active;

  fdma_buf_idx_sel #(
    .BUF_NUM(BUF_NUM)
  ) u_idx_sel (
    .cur_idx_i (wr_idx_q),
    .lock_idx_i(sel_lock_idx),
    .lock_vld_i(sel_lock_vld),
    .done_idx_i(sel_done_idx),
    .done_vld_i(sel_done_vld),
    .sel_idx_o (wr_sel)
  );

  always_comb begin
    w_state_d    = w_state_q;
    r_state_d    = r_state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    last_done_d  = last_done_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    done_valid_d = done_valid_q;
    drop_cnt_d   = drop_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    wr_start_d   = w_accept;
    rd_start_d   = r_accept;

    if (w_retire) begin
      last_done_d  = wr_idx_q;
      done_valid_d = 1'b1;
      w_state_d    = W_IDLE;
    end
    if (w_accept) begin
      wr_idx_d  = wr_sel;
      wr_addr_d = ADDR_TAB[wr_sel];
      w_state_d = W_ACTIVE;
    end
    if (w_drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Reader sees the registered last_done, so a same-cycle retire shows up next cycle
    if (r_accept) begin
      rd_idx_d  = last_done_q;
      rd_addr_d = ADDR_TAB[last_done_q];
      r_state_d = R_ACTIVE;
      if ((last_done_q == rd_idx_q) && (repeat_cnt_q != '1)) begin
        repeat_cnt_d = repeat_cnt_q + 1'b1;
      end
    end else if (r_active && bus.rd_done_i) begin
      r_state_d = R_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      last_done_q  <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      done_valid_q <= 1'b0;
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      last_done_q  <= last_done_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      done_valid_q <= done_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
      wr_start_q   <= wr_start_d;
      rd_start_q   <= rd_start_d;
    end
  end

  assign bus.wr_start_o    = wr_start_q;
  assign bus.wr_idx_o      = wr_idx_q;
  assign bus.wr_addr_o     = wr_addr_q;
  assign bus.rd_start_o    = rd_start_q;
  assign bus.rd_idx_o      = rd_idx_q;
  assign bus.rd_addr_o     = rd_addr_q;
  assign bus.frame_valid_o = done_valid_q;
  assign bus.drop_cnt_o    = drop_cnt_q;
  assign bus.repeat_cnt_o  = repeat_cnt_q;

endmodule
